// File: rtl/rf_access_sequencer_pkg.sv
// Shared types for the register-file access sequencer: opcodes, FSM states
// and default widths.
package rf_access_sequencer_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 2;
    localparam int unsigned IMM_W_DEF  = 8;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_MOV = 3'd6,
        OP_LDI = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } state_e;

    // Opcodes that fetch operands from the register file before executing.
    function automatic logic needs_read(input logic [2:0] op);
        return (op != OP_NOP) && (op != OP_LDI);
    endfunction

endpackage

// File: rtl/rf_access_sequencer_alu.sv
// Combinational ALU: result, carry/borrow and zero flag for one opcode.
// Reused by the execute stage, so it carries no state.
module rf_seq_alu
    import rf_access_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned IMM_W  = IMM_W_DEF
) (
    input  logic [2:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] wide;

    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        case (opcode_e'(opcode))
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            // The extra MSB of the widened difference is the unsigned borrow.
            OP_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_MOV:  result = a;
            OP_LDI:  result = DATA_W'(imm);
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/rf_access_sequencer.sv
// Sequences one instruction at a time through register-file read, ALU
// execute and write-back; flags commit when the write-back retires.
module rf_access_sequencer
    import rf_access_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned IMM_W  = IMM_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [IMM_W-1:0]  imm,
    output logic              rf_read_en,
    output logic [ADDR_W-1:0] rf_read_adr1,
    output logic [ADDR_W-1:0] rf_read_adr2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_write_adr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              done,
    output logic              flag_z,
    output logic              flag_c
);

    state_e            state, state_next;
    opcode_e           op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] adr1_q, adr2_q, wr_adr_q;
    logic [DATA_W-1:0] result_q;
    logic              z_next_q, c_next_q;
    logic              flag_z_q, flag_c_q;

    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry, alu_zero;

    // One ALU serves both LDI at accept (live inputs) and ALU ops in EXEC.
    assign alu_op = (state == ST_IDLE) ? opcode : op_q;

    rf_seq_alu #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_alu (
        .opcode (alu_op),
        .a      (rf_read_data1),
        .b      (rf_read_data2),
        .imm    (imm),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    assign rf_read_adr1  = adr1_q;
    assign rf_read_adr2  = adr2_q;
    assign rf_write_adr  = wr_adr_q;
    assign rf_write_data = result_q;
    assign flag_z        = flag_z_q;
    assign flag_c        = flag_c_q;

    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        rf_read_en  = 1'b0;
        rf_write_en = 1'b0;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid)
                    state_next = needs_read(opcode) ? ST_READ : ST_WB;
            end
            ST_READ: begin
                rf_read_en = 1'b1;
                state_next = ST_EXEC;
            end
            ST_EXEC: state_next = ST_WB;
            // Reset sampled in WB must suppress the write at that same edge.
            ST_WB: begin
                rf_write_en = (op_q != OP_NOP) && !reset;
                done        = !reset;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            op_q     <= OP_NOP;
            rd_q     <= '0;
            adr1_q   <= '0;
            adr2_q   <= '0;
            wr_adr_q <= '0;
            result_q <= '0;
            z_next_q <= 1'b0;
            c_next_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        op_q <= opcode_e'(opcode);
                        rd_q <= rd;
                        if (needs_read(opcode)) begin
                            adr1_q <= rs1;
                            adr2_q <= rs2;
                        end else if (opcode != OP_NOP) begin
                            wr_adr_q <= rd;
                            result_q <= alu_result;
                            z_next_q <= alu_zero;
                            c_next_q <= alu_carry;
                        end
                    end
                end
                ST_EXEC: begin
                    wr_adr_q <= rd_q;
                    result_q <= alu_result;
                    z_next_q <= alu_zero;
                    c_next_q <= alu_carry;
                end
                ST_WB: begin
                    if (op_q != OP_NOP) begin
                        flag_z_q <= z_next_q;
                        flag_c_q <= c_next_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
